// File: rtl/fp_div_sqrt_scheduler.sv
// Shares one iterative div/sqrt core between the div and sqrt issue ports (div has priority); FP_DIVSQRT_EARLY_TERM_EN lets special operands skip the core steps.
// Latency accept->wb_done is N+2 cycles (2 for early-terminated specials); result is held on wb until wb_ack, and both issue ports stay not-ready meanwhile.
module fp_div_sqrt_scheduler #(
  parameter int ID_WIDTH    = 3,
  parameter int ITER_SINGLE = 14,
  parameter int ITER_DOUBLE = 29
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_new_request,
  input  logic [ID_WIDTH-1:0] div_id,
  input  logic                div_single,
  input  logic                div_special,
  output logic                div_ready,
  input  logic                sqrt_new_request,
  input  logic [ID_WIDTH-1:0] sqrt_id,
  input  logic                sqrt_single,
  input  logic                sqrt_special,
  output logic                sqrt_ready,
  output logic                core_start,
  output logic                core_is_sqrt,
  output logic                core_single,
  output logic                core_step,
  input  logic [63:0]         core_result,
  input  logic [4:0]          core_flags,
  output logic                wb_done,
  output logic [ID_WIDTH-1:0] wb_id,
  output logic [63:0]         wb_result,
  output logic [4:0]          wb_flags,
  input  logic                wb_ack
);

  localparam int CNT_W = $clog2(ITER_DOUBLE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                is_sqrt;
    logic                single;
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic             div_acc, sqrt_acc;

`ifdef FP_DIVSQRT_EARLY_TERM_EN
  logic special_q, special_d;
`else
  logic unused_special;
  assign unused_special = div_special | sqrt_special;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      iter_cnt_q <= '0;
`ifdef FP_DIVSQRT_EARLY_TERM_EN
      special_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      iter_cnt_q <= iter_cnt_d;
`ifdef FP_DIVSQRT_EARLY_TERM_EN
      special_q  <= special_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    iter_cnt_d   = iter_cnt_q;
`ifdef FP_DIVSQRT_EARLY_TERM_EN
    special_d    = special_q;
`endif
    // Ready is a pure function of state (and div's strobe), never of wb_ack.
    div_ready    = (state_q == IDLE);
    sqrt_ready   = (state_q == IDLE) & ~div_new_request;
    div_acc      = div_ready & div_new_request;
    sqrt_acc     = sqrt_ready & sqrt_new_request;
    core_start   = 1'b0;
    core_step    = 1'b0;
    core_is_sqrt = op_q.is_sqrt;
    core_single  = op_q.single;
    wb_done      = 1'b0;
    wb_id        = op_q.id;
    wb_result    = core_result;
    wb_flags     = core_flags;

    case (state_q)
      IDLE: begin
        if (div_acc) begin
          op_d.id      = div_id;
          op_d.is_sqrt = 1'b0;
          op_d.single  = div_single;
`ifdef FP_DIVSQRT_EARLY_TERM_EN
          special_d    = div_special;
`endif
          state_d      = START;
        end else if (sqrt_acc) begin
          op_d.id      = sqrt_id;
          op_d.is_sqrt = 1'b1;
          op_d.single  = sqrt_single;
`ifdef FP_DIVSQRT_EARLY_TERM_EN
          special_d    = sqrt_special;
`endif
          state_d      = START;
        end
      end
      START: begin
        core_start = 1'b1;
        iter_cnt_d = op_q.single ? CNT_W'(ITER_SINGLE) : CNT_W'(ITER_DOUBLE);
        state_d    = RUN;
`ifdef FP_DIVSQRT_EARLY_TERM_EN
        // The core resolves special operands at load, so no iterations are needed.
        if (special_q) begin
          iter_cnt_d = '0;
          state_d    = DONE;
        end
`endif
      end
      RUN: begin
        core_step  = 1'b1;
        iter_cnt_d = iter_cnt_q - 1'b1;
        if (iter_cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        wb_done = 1'b1;
        if (wb_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_div_sqrt_scheduler.sv
// Scoreboard bench: a cycle-level transaction model predicts handshakes and completions; a negedge monitor compares.
module tb_fp_div_sqrt_scheduler;

  localparam int ITER_S = 14;
  localparam int ITER_D = 29;
`ifdef FP_DIVSQRT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        div_new_request, div_single, div_special, div_ready;
  logic [2:0]  div_id;
  logic        sqrt_new_request, sqrt_single, sqrt_special, sqrt_ready;
  logic [2:0]  sqrt_id;
  logic        core_start, core_is_sqrt, core_single, core_step;
  logic [63:0] core_result;
  logic [4:0]  core_flags;
  logic        wb_done, wb_ack;
  logic [2:0]  wb_id;
  logic [63:0] wb_result;
  logic [4:0]  wb_flags;

  fp_div_sqrt_scheduler #(.ID_WIDTH(3), .ITER_SINGLE(ITER_S), .ITER_DOUBLE(ITER_D)) dut (
    .clk(clk), .rst(rst),
    .div_new_request(div_new_request), .div_id(div_id), .div_single(div_single),
    .div_special(div_special), .div_ready(div_ready),
    .sqrt_new_request(sqrt_new_request), .sqrt_id(sqrt_id), .sqrt_single(sqrt_single),
    .sqrt_special(sqrt_special), .sqrt_ready(sqrt_ready),
    .core_start(core_start), .core_is_sqrt(core_is_sqrt), .core_single(core_single),
    .core_step(core_step), .core_result(core_result), .core_flags(core_flags),
    .wb_done(wb_done), .wb_id(wb_id), .wb_result(wb_result), .wb_flags(wb_flags),
    .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] id;
    bit         is_sqrt;
    bit         single;
    int         done_cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  int         ack_mode = 0;
  bit         m_busy = 1'b0;
  int         m_acc_cyc = 0;
  int         m_n = 0;
  logic [2:0] m_id = '0;
  bit         m_is_sqrt = 1'b0;
  bit         m_single = 1'b0;
  bit         done_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Stand-in core: loads on start, produces a fresh partial result on every step.
  initial begin
    core_result = '0;
    core_flags  = '0;
  end
  always @(posedge clk) begin
    if (core_start === 1'b1 || core_step === 1'b1) begin
      core_result <= {$urandom, $urandom};
      core_flags  <= 5'($urandom);
    end
  end

  // Transaction model: one op in flight, div wins ties, done N+2 cycles after accept.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy <= 1'b0;
      sb_q.delete();
    end else if (!m_busy) begin
      if (div_new_request || sqrt_new_request) begin
        bit         sq;
        bit         sg;
        bit         spc;
        logic [2:0] id;
        int         n;
        sq  = !div_new_request;
        id  = sq ? sqrt_id : div_id;
        sg  = sq ? sqrt_single : div_single;
        spc = sq ? sqrt_special : div_special;
        n   = (EARLY && spc) ? 0 : (sg ? ITER_S : ITER_D);
        m_busy    <= 1'b1;
        m_acc_cyc <= cyc;
        m_n       <= n;
        m_id      <= id;
        m_is_sqrt <= sq;
        m_single  <= sg;
        sb_q.push_back('{id, sq, sg, cyc + 2 + n});
      end
    end else if (cyc >= m_acc_cyc + m_n + 2 && wb_ack) begin
      m_busy <= 1'b0;
    end
  end

  // Monitor.
  always @(negedge clk) begin
    if (chk_en) begin
      int   ph;
      bit   e_start, e_step, e_done;
      exp_t e;
      ph      = cyc - m_acc_cyc;
      e_start = m_busy && ph == 1;
      e_step  = m_busy && ph >= 2 && ph <= m_n + 1;
      e_done  = m_busy && ph >= m_n + 2;
      chk("div_ready", div_ready, !m_busy);
      chk("sqrt_ready", sqrt_ready, !m_busy && !div_new_request);
      chk("core_start", core_start, e_start);
      chk("core_step", core_step, e_step);
      chk("wb_done", wb_done, e_done);
      if (m_busy && ph >= 1) begin
        chk("core_is_sqrt", core_is_sqrt, m_is_sqrt);
        chk("core_single", core_single, m_single);
      end
      if (wb_done === 1'b1) begin
        chk("wb_id", wb_id, m_id);
        chk("wb_result", wb_result, core_result);
        chk("wb_flags", wb_flags, core_flags);
        if (!done_seen) begin
          done_seen = 1'b1;
          if (sb_q.size() == 0) begin
            chk("unexpected_wb_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("sb_id", wb_id, e.id);
            chk("sb_done_cycle", cyc, e.done_cyc);
            chk("sb_is_sqrt", core_is_sqrt, e.is_sqrt);
            chk("sb_single", core_single, e.single);
          end
        end
      end else begin
        done_seen = 1'b0;
      end
    end
  end

  initial begin
    wb_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       wb_ack = 1'b1;
        1:       wb_ack = ($urandom_range(0, 2) == 0);
        default: wb_ack = m_busy && (cyc - m_acc_cyc >= m_n + 2 + 5);
      endcase
    end
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for the model to go idle, poking ignored requests while busy.
  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 300) begin
      div_new_request  = ($urandom_range(0, 5) == 0);
      sqrt_new_request = ($urandom_range(0, 3) == 0);
      div_id  = 3'($urandom);
      sqrt_id = 3'($urandom);
      step_cyc();
      n++;
    end
    div_new_request  = 1'b0;
    sqrt_new_request = 1'b0;
    if (m_busy) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic issue(input bit dv, input bit sq, input logic [2:0] did, input logic [2:0] sid,
                       input bit dsg, input bit ssg, input bit dspc, input bit sspc);
    wait_idle();
    div_new_request  = dv;  div_id  = did; div_single  = dsg; div_special  = dspc;
    sqrt_new_request = sq;  sqrt_id = sid; sqrt_single = ssg; sqrt_special = sspc;
    step_cyc();
    div_new_request  = 1'b0;
    sqrt_new_request = 1'b0;
    div_id  = 3'($urandom); div_single  = $urandom_range(0, 1); div_special  = $urandom_range(0, 1);
    sqrt_id = 3'($urandom); sqrt_single = $urandom_range(0, 1); sqrt_special = $urandom_range(0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    div_new_request = 1'b0; div_id = '0; div_single = 1'b0; div_special = 1'b0;
    sqrt_new_request = 1'b0; sqrt_id = '0; sqrt_single = 1'b0; sqrt_special = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_wb_id", wb_id, 3'd0);
    chk("rst_core_is_sqrt", core_is_sqrt, 1'b0);
    chk("rst_core_single", core_single, 1'b0);
    chk("rst_wb_done", wb_done, 1'b0);
    step_cyc();

    ack_mode = 0;
    issue(1, 0, 3'd5, 3'd0, 1, 0, 0, 0);
    issue(0, 1, 3'd0, 3'd2, 0, 0, 0, 0);
    // Simultaneous requests: div goes first, sqrt retries after its writeback.
    issue(1, 1, 3'd1, 3'd6, 1, 1, 0, 0);
    issue(0, 1, 3'd0, 3'd6, 0, 1, 0, 0);
    ack_mode = 2;
    issue(1, 0, 3'd4, 3'd0, 1, 0, 0, 0);
    wait_idle();
    ack_mode = 0;
    issue(1, 0, 3'd7, 3'd0, 1, 0, 1, 0);

    // Reset during the third RUN cycle.
    issue(1, 0, 3'd3, 3'd0, 1, 0, 0, 0);
    repeat (3) step_cyc();
    rst = 1'b1;
    step_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_wb_id", wb_id, 3'd0);
    chk("midrst_core_step", core_step, 1'b0);
    chk("midrst_wb_done", wb_done, 1'b0);
    chk("midrst_div_ready", div_ready, 1'b1);
    step_cyc();

    for (int i = 0; i < 40; i++) begin
      int k;
      ack_mode = $urandom_range(0, 2);
      k = $urandom_range(0, 3);
      if (k == 0)
        issue(1, 0, 3'($urandom), 3'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      else if (k == 1)
        issue(0, 1, 3'($urandom), 3'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      else begin
        logic [2:0] sid;
        bit         ssg, sspc;
        sid = 3'($urandom); ssg = $urandom_range(0, 1); sspc = $urandom_range(0, 1);
        issue(1, 1, 3'($urandom), sid, $urandom_range(0, 1), ssg, $urandom_range(0, 1), sspc);
        issue(0, 1, 3'($urandom), sid, 0, ssg, 0, sspc);
      end
      repeat ($urandom_range(0, 2)) step_cyc();
    end

    ack_mode = 0;
    wait_idle();
    repeat (3) step_cyc();
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
